// File: rtl/ped_sched_pkg.sv
// Shared types and defaults for the pedestrian request scheduler.
package ped_sched_pkg;

    typedef enum logic [1:0] {
        HOLDOFF = 2'd0,
        IDLE    = 2'd1,
        REQUEST = 2'd2,
        WALK    = 2'd3
    } state_t;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_t;

    localparam int DEF_MIN_GAP     = 8;
    localparam int DEF_REQ_TIMEOUT = 16;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ped_request_scheduler_press_latch.sv
// Per-crosswalk button edge detector and pending flag; clear beats a same-cycle press.
module press_latch (
    input  logic clk_1Hz,
    input  logic reset,
    input  logic btn,
    input  logic block,
    input  logic clear,
    output logic pending
);

    logic btn_prev;

    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            btn_prev <= 1'b0;
            pending  <= 1'b0;
        end else begin
            btn_prev <= btn;
            if (clear)
                pending <= 1'b0;
            else if (btn && !btn_prev && !block)
                pending <= 1'b1;
        end
    end

endmodule

// File: rtl/ped_request_scheduler.sv
// Arbitrates two crosswalk buttons into walk requests for the light controller,
// with a post-walk car gap, request timeout and emergency preemption.
module ped_request_scheduler
    import ped_sched_pkg::*;
#(
    parameter int MIN_GAP     = DEF_MIN_GAP,
    parameter int REQ_TIMEOUT = DEF_REQ_TIMEOUT
) (
    input  logic clk_1Hz,
    input  logic reset,
    input  logic btn_a,
    input  logic btn_b,
    input  logic emergency,
    input  logic ped_green,
    output logic request,
    output logic wait_a,
    output logic wait_b,
    output logic walk_a,
    output logic walk_b,
    output logic served_a,
    output logic served_b,
    output logic timeout
);

    localparam logic [7:0] GAP_END = 8'(MIN_GAP - 1);
    localparam logic [7:0] TO_END  = 8'(REQ_TIMEOUT - 1);

    state_t     state;
    side_t      grant;
    side_t      last_served;
    side_t      next_grant;
    logic [7:0] gap_cnt;
    logic [7:0] wait_cnt;
    logic       pending_a;
    logic       pending_b;
    logic       walk_exit;

    assign walk_exit = (state == WALK) && !ped_green;

    // The granted side ignores its own button for the whole walk phase.
    press_latch u_latch_a (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .btn     (btn_a),
        .block   ((state == WALK) && (grant == SIDE_A)),
        .clear   (walk_exit && (grant == SIDE_A)),
        .pending (pending_a)
    );

    press_latch u_latch_b (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .btn     (btn_b),
        .block   ((state == WALK) && (grant == SIDE_B)),
        .clear   (walk_exit && (grant == SIDE_B)),
        .pending (pending_b)
    );

    assign wait_a = pending_a;
    assign wait_b = pending_b;

    always_comb begin
        next_grant = pending_a ? SIDE_A : SIDE_B;
        if (pending_a && pending_b)
            next_grant = (last_served == SIDE_B) ? SIDE_A : SIDE_B;
    end

    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            state       <= HOLDOFF;
            grant       <= SIDE_A;
            last_served <= SIDE_B;
            gap_cnt     <= 8'd0;
            wait_cnt    <= 8'd0;
            request     <= 1'b0;
            walk_a      <= 1'b0;
            walk_b      <= 1'b0;
            served_a    <= 1'b0;
            served_b    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            served_a <= 1'b0;
            served_b <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                HOLDOFF: begin
                    request <= 1'b0;
                    if (gap_cnt == GAP_END)
                        state <= IDLE;
                    else
                        gap_cnt <= sat_inc(gap_cnt);
                end
                IDLE: begin
                    if ((pending_a || pending_b) && !emergency) begin
                        state    <= REQUEST;
                        grant    <= next_grant;
                        wait_cnt <= 8'd0;
                        request  <= 1'b1;
                    end
                end
                REQUEST: begin
                    if (emergency) begin
                        state   <= IDLE;
                        request <= 1'b0;
                    end else if (ped_green) begin
                        state  <= WALK;
                        walk_a <= (grant == SIDE_A);
                        walk_b <= (grant == SIDE_B);
                    end else if (wait_cnt == TO_END) begin
                        state   <= IDLE;
                        request <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end
                WALK: begin
                    // Request stays up; the controller ends the walk by dropping green.
                    if (!ped_green) begin
                        state       <= HOLDOFF;
                        gap_cnt     <= 8'd0;
                        request     <= 1'b0;
                        walk_a      <= 1'b0;
                        walk_b      <= 1'b0;
                        served_a    <= (grant == SIDE_A);
                        served_b    <= (grant == SIDE_B);
                        last_served <= grant;
                    end
                end
                default: state <= HOLDOFF;
            endcase
        end
    end

endmodule
